// File: rtl/ntt_pkg.sv
// Shared NTT-side types and sizes: polynomial length, coefficient width,
// BRAM address width and the readout FSM state encoding.
package ntt_pkg;

    localparam int N          = 256;
    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = $clog2(N);

    typedef logic [DATA_WIDTH-1:0] coeff_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // True for the final coefficient index of a polynomial.
    function automatic logic is_last_idx(input addr_t idx);
        return idx == addr_t'(N - 1);
    endfunction

endpackage

// File: rtl/coeff_stream_reader_if.sv
// Coefficient result stream: valid/ready beats with a last marker.
interface coeff_stream_reader_if;
    import ntt_pkg::*;

    coeff_t m_tdata;
    logic   m_tvalid;
    logic   m_tready;
    logic   m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/coeff_skid_fifo.sv
// Small synchronous FIFO absorbing BRAM read latency ahead of the stream
// output. The head comes straight from the storage flops, so the output
// data has no combinational path from push/pop. Push and pop may coincide
// at any occupancy; a push while full is only taken together with a pop.
module coeff_skid_fifo
    import ntt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  coeff_t                     din,
    input  logic                       pop,
    output coeff_t                     head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    coeff_t          mem_q [DEPTH];
    coeff_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // FIFO state register; storage clears too so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/coeff_stream_reader.sv
// Reads the N coefficients of one polynomial from the coefficient BRAM read
// port after start and presents them as a valid/ready stream. Reads are
// credit-gated on FIFO occupancy plus reads still in flight, so backpressure
// can never overflow the FIFO and m_tready never reaches bram_en
// combinationally.
// Optional build macro COEFF_CHECK_EN adds an `expected` input and a
// saturating `mismatch_cnt` output counting accepted beats that differ.
module coeff_stream_reader
    import ntt_pkg::*;
#(
    parameter int RD_LATENCY = 2,   // 1 or 2
    parameter int FIFO_DEPTH = 4    // at least RD_LATENCY + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   bram_en,
    output addr_t                  bram_addr,
    input  coeff_t                 bram_dout,
`ifdef COEFF_CHECK_EN
    input  coeff_t                 expected,
    output logic [ADDR_WIDTH:0]    mismatch_cnt,
`endif
    coeff_stream_reader_if.master  m_axis
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rd_state_e               state_q, state_d;
    addr_t                   addr_q, addr_d;
    addr_t                   beat_q, beat_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;

    logic                    land;
    logic                    pop;
    logic                    credit_ok;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    coeff_t                  fifo_head;

    coeff_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (land),
        .din   (bram_dout),
        .pop   (pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_axis.m_tvalid = !fifo_empty;
    assign m_axis.m_tdata  = fifo_head;
    assign m_axis.m_tlast  = !fifo_empty && is_last_idx(beat_q);
    assign pop             = !fifo_empty && m_axis.m_tready;
    assign land            = vld_pipe_q[RD_LATENCY-1];
    assign bram_addr       = addr_q;
    assign busy            = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done            = (state_q == ST_DONE);

    // Read-enable delay line: marks the cycle each issued read's data lands.
    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = bram_en;
        for (int i = 1; i < RD_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    // FSM next state, read issue, in-flight and beat counters.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        bram_en   = 1'b0;
        credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    beat_d  = '0;
                end
            end
            ST_READ: begin
                bram_en = credit_ok;
                if (credit_ok) begin
                    // Address holds at N-1: the last read ends the READ phase.
                    if (is_last_idx(addr_q)) state_d = ST_DRAIN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Leave as the FIFO goes empty (last beat accepted this
                // cycle), so done lands one cycle after the final beat.
                if (inflight_q == '0 &&
                    (fifo_empty || (fifo_count == CW'(1) && pop)))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) beat_d = beat_q + 1'b1;
        inflight_d = inflight_q + CW'(bram_en) - CW'(land);
    end

    // Control state register; reset discards any reads still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            inflight_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

`ifdef COEFF_CHECK_EN
    localparam logic [ADDR_WIDTH:0] MIS_MAX = (ADDR_WIDTH + 1)'(N);

    logic [ADDR_WIDTH:0] mis_q, mis_d;

    assign mismatch_cnt = mis_q;

    // Mismatch count: cleared on an accepted start, saturates at N.
    always_comb begin
        mis_d = mis_q;
        if (state_q == ST_IDLE && start)
            mis_d = '0;
        else if (pop && (fifo_head != expected) && (mis_q != MIS_MAX))
            mis_d = mis_q + 1'b1;
    end

    // Mismatch count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mis_q <= '0;
        else      mis_q <= mis_d;
    end
`endif

endmodule

// File: tb/tb_coeff_stream_reader.sv
// Self-checking bench for coeff_stream_reader: behavioural BRAM with read
// latency, a reference sequence taken straight from the memory contents,
// and scenario tasks for ordering, backpressure, stalls, restart and reset.
module tb_coeff_stream_reader;
    import ntt_pkg::*;

    localparam int L = 2;
    localparam int D = 4;

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    logic   busy, done, bram_en;
    addr_t  bram_addr;
    coeff_t bram_dout;
`ifdef COEFF_CHECK_EN
    coeff_t              expected;
    logic [ADDR_WIDTH:0] mismatch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    coeff_stream_reader_if axis();

    coeff_stream_reader #(.RD_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout),
`ifdef COEFF_CHECK_EN
        .expected     (expected),
        .mismatch_cnt (mismatch_cnt),
`endif
        .m_axis       (axis)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM read port: data appears L cycles after the enable.
    coeff_t mem [N];
    coeff_t rd_stage [L];
    always @(posedge clk) begin
        if (bram_en) rd_stage[0] <= mem[bram_addr];
        for (int i = 1; i < L; i++) rd_stage[i] <= rd_stage[i-1];
    end
    assign bram_dout = rd_stage[L-1];

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; axis.m_tready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en: got %b want 0", bram_en); end
        n_checks++; if (bram_addr !== '0) begin n_fail++; $display("FAIL reset_bram_addr: got %0d want 0", bram_addr); end
        n_checks++; if (axis.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", axis.m_tvalid); end
        n_checks++; if (axis.m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", axis.m_tlast); end
        n_checks++; if (axis.m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %0h want 0", axis.m_tdata); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Index-valued memory, ready held high: exact cycle timing of the stream.
    task automatic test_in_order();
        int cyc, beats, first_v, last_cyc, done_cyc, tlast_cnt;
        for (int i = 0; i < N; i++) mem[i] = coeff_t'(i);
        axis.m_tready = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; beats = 0; first_v = -1; last_cyc = -1; done_cyc = -1; tlast_cnt = 0;
        n_checks++;
        if ({busy, bram_en} !== 2'b11 || bram_addr !== '0) begin
            n_fail++; $display("FAIL order_first_read: got busy=%b en=%b addr=%0d want 1 1 0", busy, bram_en, bram_addr);
        end
        while (done_cyc < 0 && cyc < 600) begin
            if (axis.m_tvalid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                n_checks++;
                if (beats >= N || axis.m_tdata !== mem[beats] || axis.m_tlast !== (beats == N-1)) begin
                    n_fail++; $display("FAIL order_beat[%0d]: got data=%0d last=%b", beats, axis.m_tdata, axis.m_tlast);
                end
                if (axis.m_tlast === 1'b1) tlast_cnt++;
                last_cyc = cyc; beats++;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL order_busy_at_done: got %b want 0", busy); end
            end
            @(negedge clk); cyc++;
        end
        n_checks++; if (first_v != L + 2) begin n_fail++; $display("FAIL order_first_valid_cycle: got %0d want %0d", first_v, L + 2); end
        n_checks++; if (last_cyc != L + 1 + N) begin n_fail++; $display("FAIL order_last_beat_cycle: got %0d want %0d", last_cyc, L + 1 + N); end
        n_checks++; if (beats != N) begin n_fail++; $display("FAIL order_beat_count: got %0d want %0d", beats, N); end
        n_checks++; if (tlast_cnt != 1) begin n_fail++; $display("FAIL order_tlast_count: got %0d want 1", tlast_cnt); end
        n_checks++; if (done_cyc != last_cyc + 1) begin n_fail++; $display("FAIL order_done_cycle: got %0d want %0d", done_cyc, last_cyc + 1); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL order_done_pulse_width: got %b want 0", done); end
    endtask

    // Random data, random ready; optional ignored start pulse mid-stream.
    task automatic test_random_ready(input int restart_at);
        int     cyc, beats, issued, last_acc, done_cyc;
        bit     stalled, restarted;
        logic   rdy;
        coeff_t held;
        for (int i = 0; i < N; i++) mem[i] = coeff_t'($urandom);
        axis.m_tready = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; beats = 0; issued = 0; last_acc = -1; done_cyc = -1;
        stalled = 1'b0; restarted = 1'b0; held = '0;
        while (done_cyc < 0 && cyc < 3000) begin
            start = 1'b0;
            if (restart_at >= 0 && !restarted && beats == restart_at) begin
                start = 1'b1; restarted = 1'b1;
            end
            rdy = ($urandom_range(0, 9) < 6);
            axis.m_tready = rdy;
            if (stalled) begin
                n_checks++;
                if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== held) begin
                    n_fail++; $display("FAIL rand_stall_hold: got valid=%b data=%0h want 1 %0h", axis.m_tvalid, axis.m_tdata, held);
                end
            end
            if (bram_en === 1'b1) begin
                n_checks++;
                if (bram_addr !== addr_t'(issued)) begin
                    n_fail++; $display("FAIL rand_read_addr: got %0d want %0d", bram_addr, issued);
                end
                issued++;
                n_checks++;
                if (issued - beats > D || issued > N) begin
                    n_fail++; $display("FAIL rand_credit: got outstanding=%0d issued=%0d want <=%0d", issued - beats, issued, D);
                end
            end
            stalled = 1'b0;
            if (axis.m_tvalid === 1'b1) begin
                if (rdy) begin
                    n_checks++;
                    if (beats >= N || axis.m_tdata !== mem[beats] || axis.m_tlast !== (beats == N-1)) begin
                        n_fail++; $display("FAIL rand_beat[%0d]: got data=%0h last=%b", beats, axis.m_tdata, axis.m_tlast);
                    end
                    beats++; last_acc = cyc;
                end else begin
                    stalled = 1'b1; held = axis.m_tdata;
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                n_checks++;
                if (beats != N || done_cyc != last_acc + 1 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL rand_done: got beats=%0d cyc=%0d busy=%b want %0d %0d 0", beats, done_cyc, busy, N, last_acc + 1);
                end
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL rand_timeout: got no done want done"); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rand_done_pulse_width: got %b want 0", done); end
    endtask

    // Ready low after start: only FIFO_DEPTH reads may be issued.
    task automatic test_stall();
        int en_cnt, beats, cyc;
        for (int i = 0; i < N; i++) mem[i] = coeff_t'($urandom);
        axis.m_tready = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (bram_en === 1'b1) en_cnt++;
            @(negedge clk);
        end
        n_checks++; if (en_cnt != D) begin n_fail++; $display("FAIL stall_reads: got %0d want %0d", en_cnt, D); end
        n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL stall_en_low: got %b want 0", bram_en); end
        n_checks++; if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== mem[0]) begin
            n_fail++; $display("FAIL stall_head: got valid=%b data=%0h want 1 %0h", axis.m_tvalid, axis.m_tdata, mem[0]);
        end
        axis.m_tready = 1'b1;
        beats = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 600) begin
            if (axis.m_tvalid === 1'b1) begin
                n_checks++;
                if (beats >= N || axis.m_tdata !== mem[beats]) begin
                    n_fail++; $display("FAIL stall_beat[%0d]: got %0h", beats, axis.m_tdata);
                end
                beats++;
            end
            @(negedge clk); cyc++;
        end
        n_checks++; if (beats != N || done !== 1'b1) begin n_fail++; $display("FAIL stall_drain: got beats=%0d done=%b want %0d 1", beats, done, N); end
        @(negedge clk);
    endtask

    // Reset at beat 100, then a fresh stream must start at index 0.
    task automatic test_reset_mid();
        int beats, cyc;
        for (int i = 0; i < N; i++) mem[i] = coeff_t'($urandom);
        axis.m_tready = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 100 && cyc < 400) begin
            if (axis.m_tvalid === 1'b1) beats++;
            @(negedge clk); cyc++;
        end
        rst = 1'b0;
        #1;
        n_checks++; if (axis.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_in_reset: got %b want 0", axis.m_tvalid); end
        @(negedge clk);
        n_checks++; if ({busy, bram_en} !== 2'b00) begin n_fail++; $display("FAIL rmid_ctrl_in_reset: got busy=%b en=%b want 0 0", busy, bram_en); end
        rst = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = coeff_t'($urandom);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (axis.m_tvalid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rmid_stale_beat: got valid=%b busy=%b want 0 0", axis.m_tvalid, busy);
            end
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (axis.m_tvalid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        n_checks++; if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== mem[0] || axis.m_tlast !== 1'b0) begin
            n_fail++; $display("FAIL rmid_fresh_first: got valid=%b data=%0h last=%b want 1 %0h 0", axis.m_tvalid, axis.m_tdata, axis.m_tlast, mem[0]);
        end
        beats = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 600) begin
            if (axis.m_tvalid === 1'b1) beats++;
            @(negedge clk); cyc++;
        end
        n_checks++; if (beats != N) begin n_fail++; $display("FAIL rmid_fresh_count: got %0d want %0d", beats, N); end
        @(negedge clk);
    endtask

`ifdef COEFF_CHECK_EN
    task automatic test_check();
        int cyc;
        for (int i = 0; i < N; i++) mem[i] = coeff_t'(1);
        mem[7] = coeff_t'(5);
        expected = coeff_t'(1);
        axis.m_tready = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 600) begin @(negedge clk); cyc++; end
        n_checks++; if (done !== 1'b1 || mismatch_cnt !== 1) begin
            n_fail++; $display("FAIL check_mismatch_cnt: got done=%b cnt=%0d want 1 1", done, mismatch_cnt);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
`ifdef COEFF_CHECK_EN
        expected = '0;
`endif
        test_reset();
        test_in_order();
        test_random_ready(-1);
        test_random_ready(60);
        test_stall();
        test_reset_mid();
`ifdef COEFF_CHECK_EN
        test_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
